// File: rtl/prioritized_dispatcher.sv
// Single-input dispatcher: each accepted word goes to the free one-entry output slot
// whose priority_list value is smallest. Slots drive out_valid/out_data straight from flops.
module prioritized_dispatcher #(
    parameter int          data_width        = 8,
    parameter int          number_of_outputs = 4,
    parameter int unsigned priority_list [number_of_outputs-1:0] = '{3, 1, 2, 0}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [data_width-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [data_width-1:0] out_data  [number_of_outputs-1:0],
    output logic                  out_valid [number_of_outputs-1:0],
    input  logic                  out_ready [number_of_outputs-1:0],
    output logic [15:0]           dispatch_count
);

    logic [number_of_outputs-1:0] slot_free;
    logic [number_of_outputs-1:0] slot_sel;
    logic                         sel_found;
    int unsigned                  sel_prio;
    logic                         transfer;

    // A slot that is draining this cycle counts as free, so it can be refilled without a bubble.
    always_comb begin
        slot_free = '0;
        for (int i = 0; i < number_of_outputs; i++) begin
            slot_free[i] = !out_valid[i] || out_ready[i];
        end
    end

    assign in_ready = |slot_free;
    assign transfer = in_valid && in_ready;

    // Equal priority values resolve to the lower port index.
    always_comb begin
        slot_sel  = '0;
        sel_found = 1'b0;
        sel_prio  = '0;
        for (int i = 0; i < number_of_outputs; i++) begin
            if (slot_free[i] && (!sel_found || priority_list[i] < sel_prio)) begin
                slot_sel    = '0;
                slot_sel[i] = 1'b1;
                sel_found   = 1'b1;
                sel_prio    = priority_list[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < number_of_outputs; i++) begin
                out_valid[i] <= 1'b0;
                out_data[i]  <= '0;
            end
            dispatch_count <= '0;
        end else begin
            for (int i = 0; i < number_of_outputs; i++) begin
                if (transfer && slot_sel[i]) begin
                    out_valid[i] <= 1'b1;
                    out_data[i]  <= in_data;
                end else if (out_valid[i] && out_ready[i]) begin
                    out_valid[i] <= 1'b0;
                end
            end
            if (transfer) begin
                dispatch_count <= dispatch_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_prioritized_dispatcher.sv
// Directed bench for prioritized_dispatcher: stimulus pushes hand-computed (port, word)
// expectations into per-port queues; a monitor pops them as each port hands a word off.
module tb_prioritized_dispatcher;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data  [3:0];
    logic        out_valid [3:0];
    logic        out_ready [3:0];
    logic [15:0] dispatch_count;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q [4][$];
    logic       prev_hold [4];
    logic [7:0] prev_data [4];

    prioritized_dispatcher #(.data_width(8), .number_of_outputs(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .dispatch_count (dispatch_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic set_ready(input logic r0, input logic r1, input logic r2, input logic r3);
        out_ready[0] = r0;
        out_ready[1] = r1;
        out_ready[2] = r2;
        out_ready[3] = r3;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; the word is offered for exactly one cycle.
    task automatic send(input logic [7:0] d, input int port);
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        check($sformatf("in_ready_for_%0h", d), {31'd0, in_ready}, 32'd1);
        if (in_ready) exp_q[port].push_back(d);
        step();
        in_valid = 1'b0;
    endtask

    task automatic check_slot(input int port, input logic v, input logic [7:0] d);
        check($sformatf("out_valid[%0d]", port), {31'd0, out_valid[port]}, {31'd0, v});
        if (v) check($sformatf("out_data[%0d]", port), {24'd0, out_data[port]}, {24'd0, d});
    endtask

    // Monitor: samples after the stimulus process has pushed for this cycle.
    initial begin
        for (int i = 0; i < 4; i++) prev_hold[i] = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                for (int i = 0; i < 4; i++) begin
                    exp_q[i].delete();
                    prev_hold[i] = 1'b0;
                end
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (prev_hold[i]) begin
                        check($sformatf("hold_valid[%0d]", i), {31'd0, out_valid[i]}, 32'd1);
                        check($sformatf("hold_data[%0d]", i), {24'd0, out_data[i]}, {24'd0, prev_data[i]});
                    end
                    if (out_valid[i] && out_ready[i]) begin
                        if (exp_q[i].size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_word port=%0d actual=%0h required=none", i, out_data[i]);
                        end else begin
                            check($sformatf("port%0d_word", i), {24'd0, out_data[i]}, {24'd0, exp_q[i].pop_front()});
                        end
                    end
                    prev_hold[i] = out_valid[i] && !out_ready[i];
                    prev_data[i] = out_data[i];
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int stalls;
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hEE;
        set_ready(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset held two cycles with a word offered
        step();
        step();
        @(negedge clk);
        for (int i = 0; i < 4; i++) check_slot(i, 1'b0, 8'h00);
        check("count_in_reset", {16'd0, dispatch_count}, 32'd0);
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("in_ready_after_reset", {31'd0, in_ready}, 32'd1);
        check("count_after_reset", {16'd0, dispatch_count}, 32'd0);
        step();

        // Fill order with no consumers
        send(8'h11, 0);
        send(8'h22, 2);
        send(8'h33, 1);
        send(8'h44, 3);
        in_data  = 8'h55;
        in_valid = 1'b1;
        @(negedge clk);
        check("in_ready_full", {31'd0, in_ready}, 32'd0);
        check_slot(0, 1'b1, 8'h11);
        check_slot(2, 1'b1, 8'h22);
        check_slot(1, 1'b1, 8'h33);
        check_slot(3, 1'b1, 8'h44);
        check("count_after_fill", {16'd0, dispatch_count}, 32'd4);
        step();
        @(negedge clk);
        check("in_ready_still_full", {31'd0, in_ready}, 32'd0);
        check("count_fifth_blocked", {16'd0, dispatch_count}, 32'd4);
        step();

        // Drain port0 while 55 is pending: refill with no bubble
        set_ready(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("in_ready_on_drain", {31'd0, in_ready}, 32'd1);
        if (in_ready) exp_q[0].push_back(8'h55);
        step();
        set_ready(1'b0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        check_slot(0, 1'b1, 8'h55);
        check("count_after_refill", {16'd0, dispatch_count}, 32'd5);
        step();

        // Drain everything
        set_ready(1'b1, 1'b1, 1'b1, 1'b1);
        step();
        set_ready(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 4; i++) check_slot(i, 1'b0, 8'h00);
        step();

        // Priority among free slots: port0 busy, A0 must skip port1 for port2
        send(8'h5A, 0);
        send(8'hA0, 2);
        @(negedge clk);
        check_slot(0, 1'b1, 8'h5A);
        check_slot(2, 1'b1, 8'hA0);
        check_slot(1, 1'b0, 8'h00);
        check_slot(3, 1'b0, 8'h00);
        step();

        // Reset mid-operation discards held words
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) check_slot(i, 1'b0, 8'h00);
        check("data0_cleared", {24'd0, out_data[0]}, 32'd0);
        check("data2_cleared", {24'd0, out_data[2]}, 32'd0);
        check("count_mid_reset", {16'd0, dispatch_count}, 32'd0);
        step();
        set_ready(1'b1, 1'b1, 1'b1, 1'b1);
        step();
        step();
        set_ready(1'b0, 1'b0, 1'b0, 1'b0);

        // Fresh traffic after reset
        send(8'hB0, 0);
        send(8'hC0, 2);
        send(8'hD0, 1);
        @(negedge clk);
        check_slot(1, 1'b1, 8'hD0);
        check_slot(3, 1'b0, 8'h00);
        check("count_fresh", {16'd0, dispatch_count}, 32'd3);
        step();
        set_ready(1'b1, 1'b1, 1'b1, 1'b1);
        step();
        step();

        // Counter wrap: 65537 back-to-back transfers, all consumed by port0
        rst = 1'b1;
        step();
        rst    = 1'b0;
        stalls = 0;
        in_valid = 1'b1;
        for (int k = 0; k < 65537; k++) begin
            in_data = k[7:0];
            @(negedge clk);
            if (!in_ready) stalls++;
            else exp_q[0].push_back(k[7:0]);
            step();
        end
        in_valid = 1'b0;
        check("wrap_stall_cycles", stalls, 32'd0);
        @(negedge clk);
        check("count_wrap", {16'd0, dispatch_count}, 32'h0001);
        step();
        step();
        set_ready(1'b0, 1'b0, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 4; i++) check($sformatf("queue%0d_left", i), exp_q[i].size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
